// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-memory access block.
//   SIZE_* : access size encodings carried in the EX/MEM control bundle
//   state_e: access FSM states
//   access_t: fields latched at issue and consumed when the access completes
//   lane_be / lane_wdata / misaligned: byte-lane helpers (little-endian, 4 lanes)
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 behaves as a word too

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic [1:0]  size;
    logic        se;
    logic        l;
    logic        rf_le;
    logic [4:0]  rd;
    logic [1:0]  k;
    logic [31:0] alu;
  } access_t;

  // Byte enables for an access of the given size starting at lane k.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] k);
    case (size)
      SIZE_BYTE: lane_be = 4'b0001 << k;
      SIZE_HALF: lane_be = 4'b0011 << k;
      default:   lane_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so the addressed lanes carry it.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] store);
    case (size)
      SIZE_BYTE: lane_wdata = {4{store[7:0]}};
      SIZE_HALF: lane_wdata = {2{store[15:0]}};
      default:   lane_wdata = store;
    endcase
  endfunction

  // Halfwords need an even address, words (and size 11) a multiple of four.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] k);
    misaligned = ((size == SIZE_HALF) && k[0]) || (size[1] && (k != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_access_load_align.sv
// load_align: combinational load-data alignment.
//   rdata_i : 32-bit word returned by the data memory
//   k_i     : byte lane of the access (address bits [1:0])
//   size_i  : access size (byte / half / word)
//   se_i    : 1 = sign-extend, 0 = zero-extend
//   value_o : aligned and extended 32-bit load value
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  k_i,
  input  logic [1:0]  size_i,
  input  logic        se_i,
  output logic [31:0] value_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {k_i, 3'b000};
    case (size_i)
      SIZE_BYTE: value_o = {{24{se_i & shifted[7]}},  shifted[7:0]};
      SIZE_HALF: value_o = {{16{se_i & shifted[15]}}, shifted[15:0]};
      default:   value_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM-stage data-memory access and MEM/WB write-back register.
//   Inputs : EX/MEM bundle (E_in, RW_in, SIZE_in, SE_in, L_in, RF_LE_in, RD_in),
//            addr_in, alu_in, store_in; bus response mem_rdata/mem_ack.
//   Bus    : mem_req, mem_we, mem_addr (word aligned), mem_be, mem_wdata (registered).
//   Control: stall_out holds the upstream stages while an access is outstanding.
//   WB     : wb_rf_le, wb_rd, wb_data (registered MEM/WB bundle).
//   Faults : misalign (misaligned request, no bus cycle), bus_err (ack timeout).
//   Debug  : dbg_state exposes the access FSM state.
//
// Bus handshake: mem_req rises the cycle after an aligned request is seen in
// IDLE and stays high, with mem_we/mem_addr/mem_be/mem_wdata frozen, until a
// cycle in which mem_ack=1 (mem_rdata valid in that same cycle) or the timeout
// fires. mem_ack while mem_req=0 is ignored.
module mem_stage_access
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          E_in,
  input  logic          RW_in,
  input  logic [1:0]    SIZE_in,
  input  logic          SE_in,
  input  logic          L_in,
  input  logic          RF_LE_in,
  input  logic [4:0]    RD_in,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] alu_in,
  input  logic [DW-1:0] store_in,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall_out,
  output logic          wb_rf_le,
  output logic [4:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          misalign,
  output logic          bus_err,
  output state_e        dbg_state
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  access_t       acc_q, acc_d;

  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          wb_rf_le_q, wb_rf_le_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [DW-1:0] wb_data_q, wb_data_d;

  logic          is_mis;
  logic          timeout_hit;
  logic [31:0]   load_val;

  load_align u_load_align (
    .rdata_i (mem_rdata),
    .k_i     (acc_q.k),
    .size_i  (acc_q.size),
    .se_i    (acc_q.se),
    .value_o (load_val)
  );

  assign is_mis      = E_in && misaligned(SIZE_in, addr_in[1:0]);
  // An ack arriving on the last allowed cycle completes the access normally.
  assign timeout_hit = (state_q == ACCESS) && !mem_ack && (cnt_q == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (E_in && !is_mis)        state_d = ACCESS;
      ACCESS:  if (mem_ack || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    stall_out   = 1'b0;
    misalign    = 1'b0;
    bus_err     = 1'b0;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    wb_rf_le_d  = wb_rf_le_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;

    unique case (state_q)
      IDLE: begin
        if (!E_in) begin
          wb_rf_le_d = RF_LE_in;
          wb_rd_d    = RD_in;
          wb_data_d  = alu_in;
        end else if (is_mis) begin
          misalign   = 1'b1;
          wb_rf_le_d = 1'b0;
        end else begin
          stall_out   = 1'b1;
          acc_d       = '{size: SIZE_in, se: SE_in, l: L_in, rf_le: RF_LE_in,
                          rd: RD_in, k: addr_in[1:0], alu: alu_in};
          mem_req_d   = 1'b1;
          mem_we_d    = RW_in;
          mem_addr_d  = {addr_in[AW-1:2], 2'b00};
          mem_be_d    = lane_be(SIZE_in, addr_in[1:0]);
          mem_wdata_d = lane_wdata(SIZE_in, store_in);
          wb_rf_le_d  = 1'b0;  // bubble into MEM/WB while the access runs
          cnt_d       = '0;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          wb_rf_le_d = acc_q.rf_le;
          wb_rd_d    = acc_q.rd;
          wb_data_d  = acc_q.l ? load_val : acc_q.alu;
        end else if (timeout_hit) begin
          bus_err    = 1'b1;
          mem_req_d  = 1'b0;
          wb_rf_le_d = 1'b0;
        end else begin
          stall_out  = 1'b1;
          cnt_d      = cnt_q + CW'(1);
          wb_rf_le_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Combinational outputs are quiet while reset is held.
    if (reset) begin
      stall_out = 1'b0;
      misalign  = 1'b0;
      bus_err   = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      wb_rf_le_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      wb_rf_le_q  <= wb_rf_le_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_rf_le  = wb_rf_le_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_stage_access.sv
`timescale 1ns/1ps
module tb_mem_stage_access;
  import mem_pkg::*;

  localparam int TO = 4;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        E_in, RW_in, SE_in, L_in, RF_LE_in;
  logic [1:0]  SIZE_in;
  logic [4:0]  RD_in;
  logic [31:0] addr_in, alu_in, store_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        stall_out, wb_rf_le, misalign, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  state_e      dbg_state;

  always #5 clk = ~clk;

  mem_stage_access #(.TIMEOUT(TO), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .E_in(E_in), .RW_in(RW_in), .SIZE_in(SIZE_in), .SE_in(SE_in), .L_in(L_in),
    .RF_LE_in(RF_LE_in), .RD_in(RD_in), .addr_in(addr_in), .alu_in(alu_in),
    .store_in(store_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_out(stall_out), .wb_rf_le(wb_rf_le), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int          stall;
    bit          mis, berr, hung, unstable;
    int          berr_at;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        wb_rf_le;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        req_after;
    logic        state_after;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_mis(input logic [1:0] size, input logic [31:0] addr);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] addr);
    int n = nbytes(size);
    int k = int'(addr % 4);
    return 4'(((1 << n) - 1) << k);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] store);
    logic [31:0] w;
    int n = nbytes(size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = store[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [1:0] size, input logic se);
    longint unsigned span = 64'd1 << (8 * nbytes(size));
    longint v = longint'(rdata) >> (8 * (addr % 4));
    v = v % longint'(span);
    if (se && v >= longint'(span / 2)) v = v - longint'(span);
    return 32'(v);
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    E_in = 0; RW_in = 0; SIZE_in = 0; SE_in = 0; L_in = 0; RF_LE_in = 0;
    RD_in = 0; addr_in = 0; alu_in = 0; store_in = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  // Starts at posedge+1 in IDLE, issues one request, answers with mem_ack after
  // ack_wait ACCESS cycles (ack_wait >= TO means never), ends at posedge+1.
  task automatic drive_access(input logic rw, input logic [1:0] size, input logic se,
                              input logic l, input logic rf_le, input logic [4:0] rd,
                              input logic [31:0] addr, input logic [31:0] alu,
                              input logic [31:0] store, input logic [31:0] rdata,
                              input int ack_wait, output obs_t o);
    int n;
    bit done;
    o = '{default: 0};
    o.berr_at = -1;
    E_in = 1; RW_in = rw; SIZE_in = size; SE_in = se; L_in = l; RF_LE_in = rf_le;
    RD_in = rd; addr_in = addr; alu_in = alu; store_in = store; mem_ack = 0;
    #1;
    o.mis = misalign;
    if (stall_out) o.stall++;
    @(posedge clk); #1;
    o.req = mem_req; o.we = mem_we; o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata;
    // upstream moves on; the latched copy must be used from here
    E_in = 0; RF_LE_in = 1'($urandom); RD_in = 5'($urandom); alu_in = $urandom;
    store_in = $urandom; addr_in = $urandom; SIZE_in = 2'($urandom); SE_in = 1'($urandom);
    L_in = 1'($urandom);
    if (!o.mis) begin
      n = 0; done = 0;
      while (!done) begin
        mem_ack = (n == ack_wait);
        mem_rdata = mem_ack ? rdata : $urandom;
        #1;
        if (stall_out) o.stall++;
        if (bus_err) begin o.berr = 1; o.berr_at = n; end
        if (mem_req !== o.req || mem_we !== o.we || mem_addr !== o.addr ||
            mem_be !== o.be || mem_wdata !== o.wdata) o.unstable = 1;
        done = mem_ack || bus_err;
        @(posedge clk); #1;
        n++;
        if (!done && n > TO + 2) begin o.hung = 1; done = 1; end
      end
      mem_ack = 0;
    end
    o.wb_rf_le = wb_rf_le; o.wb_rd = wb_rd; o.wb_data = wb_data;
    o.req_after = mem_req; o.state_after = dbg_state;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1;
    E_in = 1; SIZE_in = SIZE_WORD; addr_in = 32'h40; mem_ack = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({mem_req, mem_we, mem_be, wb_rf_le, stall_out, misalign, bus_err} !== 10'd0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0", {mem_req, mem_we, mem_be, wb_rf_le, stall_out, misalign, bus_err}); end
    checks++; if ({mem_addr, mem_wdata, wb_data, wb_rd} !== 101'd0) begin
      errors++; $display("FAIL reset_data addr %h wdata %h wb_data %h wb_rd %0d exp 0", mem_addr, mem_wdata, wb_data, wb_rd); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dbg_state); end
    idle_inputs();
    reset = 0;
  endtask

  task automatic test_word_load();
    obs_t o;
    drive_access(0, SIZE_WORD, 0, 1, 1, 5'd5, 32'h100, 32'h1111, 32'h0, 32'hDEADBEEF, 0, o);
    checks++; if (o.stall !== 1) begin errors++; $display("FAIL word_load_stall got %0d exp 1", o.stall); end
    checks++; if (o.be !== 4'b1111 || o.addr !== 32'h100 || o.req !== 1'b1 || o.we !== 1'b0) begin
      errors++; $display("FAIL word_load_bus be %b addr %h req %b we %b exp 1111 100 1 0", o.be, o.addr, o.req, o.we); end
    checks++; if (o.wb_rf_le !== 1'b1 || o.wb_rd !== 5'd5 || o.wb_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_load_wb le %b rd %0d data %h exp 1 5 deadbeef", o.wb_rf_le, o.wb_rd, o.wb_data); end
    checks++; if (o.req_after !== 1'b0 || o.state_after !== IDLE) begin
      errors++; $display("FAIL word_load_done req %b state %b exp 0 IDLE", o.req_after, o.state_after); end
  endtask

  task automatic test_byte_load();
    obs_t o;
    drive_access(0, SIZE_BYTE, 1, 1, 1, 5'd7, 32'h103, 32'h0, 32'h0, 32'h80112233, 0, o);
    checks++; if (o.mis !== 1'b0 || o.be !== 4'b1000) begin
      errors++; $display("FAIL byte_load_be mis %b be %b exp 0 1000", o.mis, o.be); end
    checks++; if (o.wb_data !== 32'hFFFFFF80 || o.wb_rd !== 5'd7) begin
      errors++; $display("FAIL byte_load_sext got %h rd %0d exp ffffff80 7", o.wb_data, o.wb_rd); end
    drive_access(0, SIZE_BYTE, 0, 1, 1, 5'd7, 32'h103, 32'h0, 32'h0, 32'h80112233, 0, o);
    checks++; if (o.wb_data !== 32'h00000080) begin
      errors++; $display("FAIL byte_load_zext got %h exp 00000080", o.wb_data); end
  endtask

  task automatic test_half_store();
    obs_t o;
    drive_access(1, SIZE_HALF, 0, 0, 0, 5'd3, 32'h202, 32'h55, 32'h0000ABCD, 32'h0, 0, o);
    checks++; if (o.we !== 1'b1 || o.be !== 4'b1100 || o.wdata !== 32'hABCDABCD || o.addr !== 32'h200) begin
      errors++; $display("FAIL half_store_bus we %b be %b wdata %h addr %h exp 1 1100 abcdabcd 200", o.we, o.be, o.wdata, o.addr); end
    checks++; if (o.wb_rf_le !== 1'b0) begin errors++; $display("FAIL half_store_wb got %b exp 0", o.wb_rf_le); end
  endtask

  task automatic test_misalign();
    obs_t o;
    logic [1:0]  sizes[2] = '{SIZE_WORD, SIZE_HALF};
    logic [31:0] addrs[2] = '{32'h101, 32'h203};
    for (int i = 0; i < 2; i++) begin
      E_in = 0; RF_LE_in = 1; RD_in = 5'd2; alu_in = 32'h77;  // leave wb_rf_le=1 beforehand
      @(posedge clk); #1;
      drive_access(0, sizes[i], 0, 1, 1, 5'd9, addrs[i], 32'h0, 32'h0, 32'h0, 0, o);
      checks++; if (o.mis !== 1'b1 || o.stall !== 0) begin
        errors++; $display("FAIL misalign_%0d pulse %b stall %0d exp 1 0", i, o.mis, o.stall); end
      checks++; if (o.req !== 1'b0 || o.wb_rf_le !== 1'b0 || o.state_after !== IDLE) begin
        errors++; $display("FAIL misalign_%0d_effect req %b wb_rf_le %b state %b exp 0 0 IDLE", i, o.req, o.wb_rf_le, o.state_after); end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_access(0, SIZE_WORD, 0, 1, 1, 5'd4, 32'h300, 32'h0, 32'h0, 32'h0, TO, o);
    checks++; if (o.stall !== TO) begin errors++; $display("FAIL timeout_stall got %0d exp %0d", o.stall, TO); end
    checks++; if (o.berr !== 1'b1 || o.berr_at !== TO - 1 || o.hung) begin
      errors++; $display("FAIL timeout_berr seen %b at %0d hung %b exp 1 %0d 0", o.berr, o.berr_at, o.hung, TO - 1); end
    checks++; if (o.req_after !== 1'b0 || o.state_after !== IDLE || o.wb_rf_le !== 1'b0) begin
      errors++; $display("FAIL timeout_after req %b state %b wb_rf_le %b exp 0 IDLE 0", o.req_after, o.state_after, o.wb_rf_le); end
    drive_access(0, SIZE_WORD, 0, 1, 1, 5'd12, 32'h304, 32'h0, 32'h0, 32'h0BADF00D, TO - 1, o);
    checks++; if (o.berr !== 1'b0 || o.wb_rf_le !== 1'b1 || o.wb_rd !== 5'd12 || o.wb_data !== 32'h0BADF00D) begin
      errors++; $display("FAIL ack_on_timeout berr %b le %b rd %0d data %h exp 0 1 12 0badf00d", o.berr, o.wb_rf_le, o.wb_rd, o.wb_data); end
  endtask

  task automatic test_reset_in_access();
    E_in = 1; RW_in = 0; SIZE_in = SIZE_WORD; addr_in = 32'h400; L_in = 1; RF_LE_in = 1; RD_in = 5'd8;
    @(posedge clk); #1;
    E_in = 0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_acc_pre req %b exp 1", mem_req); end
    reset = 1;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0 || wb_rf_le !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL rst_acc req %b le %b rd %0d data %h state %0d exp all 0", mem_req, wb_rf_le, wb_rd, wb_data, dbg_state); end
    reset = 0; RF_LE_in = 1; RD_in = 5'd9; alu_in = 32'h12345678; mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0;
    checks++; if (wb_data !== 32'h12345678 || wb_rf_le !== 1'b1 || wb_rd !== 5'd9 || mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_acc_pass data %h le %b rd %0d req %b exp 12345678 1 9 0", wb_data, wb_rf_le, wb_rd, mem_req); end
  endtask

  task automatic test_passthrough();
    logic exp_le;
    logic [4:0] exp_rd;
    for (int i = 0; i < 20; i++) begin
      E_in = 0; RF_LE_in = 1'($urandom); RD_in = 5'($urandom); alu_in = $urandom;
      mem_ack = 1'($urandom); mem_rdata = $urandom; addr_in = $urandom; SIZE_in = 2'($urandom);
      exp_le = RF_LE_in; exp_rd = RD_in; exp_q.push_back(alu_in);
      #1;
      checks++; if (stall_out !== 1'b0 || misalign !== 1'b0 || bus_err !== 1'b0) begin
        errors++; $display("FAIL pass_comb stall %b mis %b berr %b exp 0", stall_out, misalign, bus_err); end
      @(posedge clk); #1;
      checks++; if (wb_data !== exp_q.pop_front() || wb_rf_le !== exp_le || wb_rd !== exp_rd || mem_req !== 1'b0 || dbg_state !== IDLE) begin
        errors++; $display("FAIL pass_%0d data %h le %b rd %0d req %b state %0d", i, wb_data, wb_rf_le, wb_rd, mem_req, dbg_state); end
    end
    mem_ack = 0;
  endtask

  task automatic test_random();
    obs_t o;
    logic rw, se, l, rf_le;
    logic [1:0] size;
    logic [4:0] rd;
    logic [31:0] addr, alu, store, rdata, exp_wd;
    int ack_wait, exp_stall;
    bit mis, acked;
    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom); se = 1'($urandom); l = 1'($urandom); rf_le = 1'($urandom);
      size = 2'($urandom_range(0, 3)); rd = 5'($urandom); addr = $urandom & 32'hFFF;
      alu = $urandom; store = $urandom; rdata = $urandom; ack_wait = $urandom_range(0, TO);
      mis = ref_mis(size, addr);
      acked = !mis && (ack_wait < TO);
      exp_stall = mis ? 0 : (ack_wait < TO) ? 1 + ack_wait : TO;
      drive_access(rw, size, se, l, rf_le, rd, addr, alu, store, rdata, ack_wait, o);
      checks++; if (o.mis !== mis || o.stall !== exp_stall || o.req !== !mis || o.hung) begin
        errors++; $display("FAIL rand_%0d_ctrl mis %b/%b stall %0d/%0d req %b hung %b", i, o.mis, mis, o.stall, exp_stall, o.req, o.hung); end
      if (!mis) begin
        checks++; if (o.we !== rw || o.addr !== (addr & ~32'h3) || o.be !== ref_be(size, addr) ||
                      o.wdata !== ref_wdata(size, store) || o.unstable) begin
          errors++; $display("FAIL rand_%0d_bus we %b addr %h be %b wdata %h unstable %b exp %b %h %b %h 0", i,
                             o.we, o.addr, o.be, o.wdata, o.unstable, rw, addr & ~32'h3, ref_be(size, addr), ref_wdata(size, store)); end
        checks++; if (o.berr !== (ack_wait >= TO)) begin
          errors++; $display("FAIL rand_%0d_berr got %b exp %b", i, o.berr, ack_wait >= TO); end
      end
      checks++; if (o.wb_rf_le !== (acked && rf_le) || o.req_after !== 1'b0 || o.state_after !== IDLE) begin
        errors++; $display("FAIL rand_%0d_end le %b req %b state %b exp %b 0 IDLE", i, o.wb_rf_le, o.req_after, o.state_after, acked && rf_le); end
      if (acked) begin
        exp_q.push_back(l ? ref_load(rdata, addr, size, se) : alu);
        exp_wd = exp_q.pop_front();
        checks++; if (o.wb_data !== exp_wd || o.wb_rd !== rd) begin
          errors++; $display("FAIL rand_%0d_wb data %h rd %0d exp %h %0d", i, o.wb_data, o.wb_rd, exp_wd, rd); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    @(posedge clk); #1;
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misalign();
    test_timeout();
    test_reset_in_access();
    test_passthrough();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- MEM-stage consumer of the EX/MEM pipeline register's control bundle (RW, E, SIZE, RF_LE, L, SE, RD) plus address and store data.
- Runs byte/halfword/word accesses on a req/ack data-memory bus, aligns and extends load data, and registers the result into the MEM/WB write-back bundle.
- Stalls upstream stages while an access is outstanding.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16, ACCESS-state cycles without mem_ack before bus error (≥1)
- AW, 32, address width
- DW, 32, data width (fixed 32; byte lanes = 4)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- E_in  in  1  memory enable
- RW_in  in  1  0=read, 1=write
- SIZE_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
- SE_in  in  1  sign-extend loads
- L_in  in  1  write-back source: 1=memory data, 0=alu_in
- RF_LE_in  in  1  register-file load enable
- RD_in  in  5  destination register
- addr_in  in  AW  effective address
- alu_in  in  32  ALU result (non-load write-back value)
- store_in  in  32  store data (low bits significant)
- mem_req  out  1  bus request, held until ack or timeout
- mem_we  out  1  write strobe
- mem_addr  out  AW  word-aligned address (addr[1:0]=00)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  single-cycle completion
- stall_out  out  1  hold PC/IF_ID/ID_EX/EX_MEM this cycle
- wb_rf_le  out  1  registered RF enable to MEM/WB
- wb_rd  out  5  registered destination
- wb_data  out  32  registered write-back data
- misalign  out  1  one-cycle fault pulse
- bus_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0. A reset during ACCESS drops mem_req at that edge. No pending access survives reset.
- States: IDLE, ACCESS.
- Misaligned access: E_in=1 with (SIZE=01 and addr[0]=1) or (SIZE=1x and addr[1:0]≠00).
  - Stays in IDLE; no bus cycle.
  - misalign=1 for one cycle.
  - wb_rf_le<=0; stall_out=0.
- IDLE, E_in=0: pass-through.
  - wb_rf_le<=RF_LE_in, wb_rd<=RD_in, wb_data<=alu_in.
  - stall_out=0; one-cycle latency.
- IDLE, E_in=1, aligned:
  - stall_out=1 (combinational).
  - Latch RW, SIZE, SE, L, RF_LE, RD, addr[1:0], alu_in.
  - Drive mem_req=1, mem_we=RW_in, mem_addr, mem_be, mem_wdata (all registered).
  - wb_rf_le<=0 (bubble); next state ACCESS; counter<=0.
- ACCESS, mem_ack=0:
  - stall_out=1; counter++; wb_rf_le<=0.
  - When counter reaches TIMEOUT-1: bus_err=1, mem_req<=0, stall_out=0, wb_rf_le<=0, next IDLE.
- ACCESS, mem_ack=1:
  - stall_out=0; mem_req<=0; next IDLE.
  - wb_rf_le<=latched RF_LE, wb_rd<=latched RD.
  - wb_data<=load_align(mem_rdata) if latched L, else latched alu value.
  - Minimum access latency 2 cycles, with stall high for 1 cycle.
- Simultaneous events:
  - mem_ack on the timeout cycle: ack wins, no bus_err.
  - mem_ack in IDLE: ignored.
- Byte lanes, little-endian: lane k = bits [8k+7:8k], k=addr[1:0].
  - Byte: be=0001<<k, wdata={4{store[7:0]}}.
  - Half: be=0011<<k, wdata={2{store[15:0]}}.
  - Word: be=1111, wdata=store.
  - Reads drive be as for writes.
- Load extraction: rdata>>(8·k), keep 8/16/32 bits, then sign-extend if SE else zero-extend.
- mem_addr, mem_we, mem_be, mem_wdata are stable while mem_req=1.

Decomposition:
- Package mem_pkg:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants
  - state enum {IDLE, ACCESS}
  - lane/byte-enable helper function
- Sub-module load_align: combinational extract+extend; inputs rdata, k, size, se; output 32-bit value.

Test Plan:
- Word load addr=0x100, SE=0, RF_LE=1, RD=5, ack on first ACCESS cycle, rdata=0xDEADBEEF:
  - stall high 1 cycle
  - mem_be=1111, mem_addr=0x100
  - next edge wb_rd=5, wb_rf_le=1, wb_data=0xDEADBEEF
- Byte load addr=0x103, SE=1, rdata=0x80112233:
  - be=1000
  - wb_data=0xFFFFFF80
  - repeat with SE=0 → 0x00000080
- Half store addr=0x202, store_in=0x0000ABCD, RW=1, RF_LE=0:
  - mem_we=1, be=1100, wdata=0xABCDABCD, addr=0x200
  - wb_rf_le=0 after ack
- Misaligned word addr=0x101:
  - misalign pulse, mem_req stays 0, stall_out=0, wb_rf_le=0
- No ack, TIMEOUT=4:
  - stall high 4 cycles
  - bus_err pulse on 4th ACCESS cycle, mem_req drops, IDLE
  - variant with ack on that same cycle: no bus_err, data written back
- Reset asserted during ACCESS:
  - next edge mem_req=0, all wb outputs 0, IDLE
  - following E_in=0 op passes alu_in through
